// File: rtl/bp_pht_gshare_if.sv
// Lookup, update and status bundle between the IF-stage predictor, the
// gshare PHT and the EX/IS branch-resolution bus.
interface bp_pht_gshare_if #(
    parameter int IDX_W = 10,
    parameter int CTR_W = 2,
    parameter int GHR_W = 8
);
    logic             pred_valid;
    logic [31:0]      pred_pc;
    logic             pred_ready;
    logic             pred_rvalid;
    logic             pred_taken;
    logic [CTR_W-1:0] pred_ctr;
    logic [IDX_W-1:0] pred_idx;
    logic [GHR_W-1:0] pred_ghr;

    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             upd_mispred;
    logic [GHR_W-1:0] upd_ghr;

    logic [GHR_W-1:0] ghr_o;
    logic             init_busy;

    modport master (
        output pred_valid, pred_pc,
        output upd_valid, upd_idx, upd_taken, upd_mispred, upd_ghr,
        input  pred_ready, pred_rvalid, pred_taken, pred_ctr, pred_idx, pred_ghr,
        input  ghr_o, init_busy
    );

    modport slave (
        input  pred_valid, pred_pc,
        input  upd_valid, upd_idx, upd_taken, upd_mispred, upd_ghr,
        output pred_ready, pred_rvalid, pred_taken, pred_ctr, pred_idx, pred_ghr,
        output ghr_o, init_busy
    );
endinterface

// File: rtl/bp_pht_gshare.sv
// Gshare pattern history table: owns the global history, hashes it with the
// fetch PC, performs saturating-counter updates and self-initialises by sweep.
module bp_pht_gshare #(
    parameter int IDX_W    = 10,
    parameter int CTR_W    = 2,
    parameter int GHR_W    = 8,
    parameter int INIT_VAL = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    bp_pht_gshare_if.slave   bus
);
    localparam int               DEPTH      = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX    = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_ZERO   = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0] CTR_ONE    = CTR_W'(1);
    localparam logic [CTR_W-1:0] CTR_INIT   = CTR_W'(INIT_VAL);
    localparam logic [IDX_W-1:0] SWEEP_LAST = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_ZERO   = {IDX_W{1'b0}};
    localparam logic [GHR_W-1:0] GHR_ZERO   = {GHR_W{1'b0}};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [CTR_W-1:0] sat_step(input logic [CTR_W-1:0] ctr,
                                                  input logic             up);
        logic [CTR_W-1:0] res;
        if (up) begin
            res = (ctr == CTR_MAX) ? ctr : ctr + CTR_ONE;
        end else begin
            res = (ctr == CTR_ZERO) ? ctr : ctr - CTR_ONE;
        end
        return res;
    endfunction

    // Shift one outcome bit into a history value; the oldest bit falls off.
    function automatic logic [GHR_W-1:0] ghr_shift(input logic [GHR_W-1:0] hist,
                                                   input logic             bit_in);
        return GHR_W'({hist, bit_in});
    endfunction

    state_t           state_r;
    logic [IDX_W-1:0] sweep_r;
    logic             busy_r;
    logic             ready_r;
    logic [GHR_W-1:0] ghr_r;
    logic             rvalid_r;
    logic             taken_r;
    logic [CTR_W-1:0] ctr_r;
    logic [IDX_W-1:0] idx_r;
    logic [GHR_W-1:0] snap_r;
    logic [CTR_W-1:0] ctr_tbl_r [DEPTH];

    logic             run_s;
    logic             lkp_do_s;
    logic             upd_do_s;
    logic [IDX_W-1:0] idx_s;
    logic [CTR_W-1:0] upd_cur_s;
    logic [CTR_W-1:0] upd_new_s;
    logic [CTR_W-1:0] rd_s;
    logic [GHR_W-1:0] ghr_next_s;
    logic             unused_pc_s;

    assign unused_pc_s = ^{bus.pred_pc[31:IDX_W+2], bus.pred_pc[1:0]};

    // Request qualification, index hash and update read-modify-write value.
    always_comb begin
        run_s     = (state_r == ST_RUN);
        lkp_do_s  = bus.pred_valid & ready_r & ~clr;
        upd_do_s  = bus.upd_valid & run_s & ~clr;
        idx_s     = bus.pred_pc[IDX_W+1:2] ^ IDX_W'(ghr_r);
        upd_cur_s = ctr_tbl_r[bus.upd_idx];
        upd_new_s = sat_step(upd_cur_s, bus.upd_taken);
        // A same-cycle update to the looked-up entry must be seen by the lookup.
        if (upd_do_s && (bus.upd_idx == idx_s)) begin
            rd_s = upd_new_s;
        end else begin
            rd_s = ctr_tbl_r[idx_s];
        end
    end

    // Next global history: recovery beats speculation; cleared outside RUN.
    always_comb begin
        ghr_next_s = ghr_r;
        if (!run_s || clr) begin
            ghr_next_s = GHR_ZERO;
        end else if (upd_do_s && bus.upd_mispred) begin
            ghr_next_s = ghr_shift(bus.upd_ghr, bus.upd_taken);
        end else if (rvalid_r) begin
            ghr_next_s = ghr_shift(ghr_r, taken_r);
        end else begin
            ghr_next_s = ghr_r;
        end
    end

    // Init-sweep / run control FSM with registered status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_INIT;
            sweep_r <= IDX_ZERO;
            busy_r  <= 1'b1;
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    sweep_r <= sweep_r + IDX_W'(1);
                    if (sweep_r == SWEEP_LAST) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_INIT;
                    end
                end
                ST_RUN: begin
                    if (clr) begin
                        state_r <= ST_INIT;
                        sweep_r <= IDX_ZERO;
                        busy_r  <= 1'b1;
                        ready_r <= 1'b0;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_INIT;
                    sweep_r <= IDX_ZERO;
                    busy_r  <= 1'b1;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Registered lookup result and global history.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rvalid_r <= 1'b0;
            taken_r  <= 1'b0;
            ctr_r    <= CTR_ZERO;
            idx_r    <= IDX_ZERO;
            snap_r   <= GHR_ZERO;
            ghr_r    <= GHR_ZERO;
        end else begin
            rvalid_r <= lkp_do_s;
            ghr_r    <= ghr_next_s;
            if (lkp_do_s) begin
                ctr_r  <= rd_s;
                taken_r <= rd_s[CTR_W-1];
                idx_r  <= idx_s;
                snap_r <= ghr_r;
            end
        end
    end

    // Counter array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (state_r == ST_INIT) begin
            ctr_tbl_r[sweep_r] <= CTR_INIT;
        end else if (upd_do_s) begin
            ctr_tbl_r[bus.upd_idx] <= upd_new_s;
        end
    end

    assign bus.pred_ready  = ready_r;
    assign bus.pred_rvalid = rvalid_r;
    assign bus.pred_taken  = taken_r;
    assign bus.pred_ctr    = ctr_r;
    assign bus.pred_idx    = idx_r;
    assign bus.pred_ghr    = snap_r;
    assign bus.ghr_o       = ghr_r;
    assign bus.init_busy   = busy_r;
endmodule

// File: tb/tb_bp_pht_gshare.sv
// Self-checking bench for bp_pht_gshare: directed scenarios plus randomized
// traffic compared against an integer-level reference model.
module tb_bp_pht_gshare;
    localparam int IDX_W    = 4;
    localparam int CTR_W    = 2;
    localparam int GHR_W    = 4;
    localparam int INIT_VAL = 1;
    localparam int DEPTH    = 1 << IDX_W;
    localparam int GHR_MOD  = 1 << GHR_W;
    localparam int CMAX     = (1 << CTR_W) - 1;

    logic clk = 1'b0;
    logic resetn;
    logic clr;
    always #5 clk = ~clk;

    bp_pht_gshare_if #(.IDX_W(IDX_W), .CTR_W(CTR_W), .GHR_W(GHR_W)) bus ();

    bp_pht_gshare #(.IDX_W(IDX_W), .CTR_W(CTR_W), .GHR_W(GHR_W), .INIT_VAL(INIT_VAL)) dut (
        .clk    (clk),
        .resetn (resetn),
        .clr    (clr),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state.
    int m_tbl [DEPTH];
    bit m_run;
    int m_left;
    int m_ghr;
    bit m_rvalid;
    bit m_taken;
    int m_ctr;
    int m_idx;
    int m_snap;

    task automatic idle_inputs();
        clr             = 1'b0;
        bus.pred_valid  = 1'b0;
        bus.pred_pc     = 32'h0;
        bus.upd_valid   = 1'b0;
        bus.upd_idx     = 4'h0;
        bus.upd_taken   = 1'b0;
        bus.upd_mispred = 1'b0;
        bus.upd_ghr     = 4'h0;
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_left = DEPTH; m_ghr = 0; m_rvalid = 1'b0;
        m_taken = 1'b0; m_ctr = 0; m_idx = 0; m_snap = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int idx, nghr, u, v;
        if (!m_run) begin
            m_tbl[DEPTH - m_left] = INIT_VAL;
            m_left--;
            if (m_left == 0) m_run = 1'b1;
            m_rvalid = 1'b0;
            m_ghr = 0;
        end else if (clr) begin
            m_run = 1'b0; m_left = DEPTH; m_ghr = 0; m_rvalid = 1'b0;
        end else begin
            idx  = (int'((bus.pred_pc >> 2) % DEPTH) ^ m_ghr) % DEPTH;
            nghr = m_ghr;
            if (m_rvalid) nghr = (m_ghr * 2 + int'(m_taken)) % GHR_MOD;
            if (bus.upd_valid && bus.upd_mispred)
                nghr = (int'(bus.upd_ghr) * 2 + int'(bus.upd_taken)) % GHR_MOD;
            if (bus.upd_valid) begin
                u = int'(bus.upd_idx);
                v = m_tbl[u] + (bus.upd_taken ? 1 : -1);
                if (v > CMAX) v = CMAX;
                if (v < 0) v = 0;
                m_tbl[u] = v;
            end
            if (bus.pred_valid) begin
                m_ctr = m_tbl[idx]; m_taken = (m_ctr >= (1 << (CTR_W - 1)));
                m_idx = idx; m_snap = m_ghr; m_rvalid = 1'b1;
            end else begin
                m_rvalid = 1'b0;
            end
            m_ghr = nghr;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pc_for(input int idx);
        return 32'(((idx ^ m_ghr) % DEPTH) * 4);
    endfunction

    task automatic test_reset();
        int cnt;
        idle_inputs();
        resetn = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus.init_busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b expected 1", bus.init_busy); end
        tests++; if (bus.pred_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", bus.pred_ready); end
        tests++; if (bus.pred_rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid: got %b expected 0", bus.pred_rvalid); end
        tests++; if (bus.ghr_o !== 4'h0) begin fails++; $display("FAIL reset_ghr: got %h expected 0", bus.ghr_o); end
        tests++; if (bus.pred_ctr !== 2'd0 || bus.pred_idx !== 4'h0) begin fails++; $display("FAIL reset_outs: ctr %0d idx %0d expected 0 0", bus.pred_ctr, bus.pred_idx); end
        resetn = 1'b1;
        cnt = 0;
        while (bus.init_busy === 1'b1 && cnt < 40) begin
            tests++; if (bus.pred_ready !== 1'b0) begin fails++; $display("FAIL init_ready_low: got %b expected 0 at cycle %0d", bus.pred_ready, cnt); end
            tick();
            cnt++;
        end
        tests++; if (cnt != DEPTH) begin fails++; $display("FAIL init_cycles: got %0d expected %0d", cnt, DEPTH); end
        tests++; if (bus.pred_ready !== 1'b1) begin fails++; $display("FAIL init_ready_high: got %b expected 1", bus.pred_ready); end
    endtask

    task automatic test_init_values();
        for (int i = 0; i < DEPTH; i++) begin
            idle_inputs();
            bus.pred_valid = 1'b1;
            bus.pred_pc    = 32'(i * 4);
            tick();
            tests++;
            if (bus.pred_rvalid !== 1'b1 || bus.pred_ctr !== 2'd1 || bus.pred_taken !== 1'b0 || bus.pred_idx !== 4'(i)) begin
                fails++;
                $display("FAIL init_value[%0d]: rvalid %b ctr %0d taken %b idx %0d expected 1 1 0 %0d",
                         i, bus.pred_rvalid, bus.pred_ctr, bus.pred_taken, bus.pred_idx, i);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_saturation();
        for (int dir = 1; dir >= 0; dir--) begin
            for (int k = 0; k < 4 + (1 - dir); k++) begin
                idle_inputs();
                bus.upd_valid = 1'b1; bus.upd_idx = 4'd5; bus.upd_taken = 1'(dir);
                tick();
            end
            idle_inputs();
            bus.pred_valid = 1'b1; bus.pred_pc = pc_for(5);
            tick();
            tests++;
            if (bus.pred_ctr !== (dir ? 2'd3 : 2'd0) || bus.pred_taken !== 1'(dir) || bus.pred_idx !== 4'd5) begin
                fails++;
                $display("FAIL saturation_dir%0d: ctr %0d taken %b idx %0d expected %0d %0d 5",
                         dir, bus.pred_ctr, bus.pred_taken, bus.pred_idx, dir ? 3 : 0, dir);
            end
            idle_inputs();
            tick();
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        bus.upd_valid = 1'b1; bus.upd_idx = 4'd7; bus.upd_taken = 1'b1;
        bus.pred_valid = 1'b1; bus.pred_pc = pc_for(7);
        tick();
        tests++;
        if (bus.pred_ctr !== 2'd2 || bus.pred_taken !== 1'b1 || bus.pred_idx !== 4'd7) begin
            fails++;
            $display("FAIL bypass: ctr %0d taken %b idx %0d expected 2 1 7", bus.pred_ctr, bus.pred_taken, bus.pred_idx);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_ghr();
        int targets [3] = '{8, 9, 10};
        for (int k = 0; k < 4; k++) begin
            idle_inputs();
            bus.upd_valid = 1'b1; bus.upd_idx = 4'(8 + k / 2); bus.upd_taken = 1'b1;
            tick();
        end
        idle_inputs();
        bus.upd_valid = 1'b1; bus.upd_mispred = 1'b1; bus.upd_idx = 4'd0; bus.upd_ghr = 4'h0;
        tick();
        idle_inputs();
        tick();
        tests++; if (bus.ghr_o !== 4'h0) begin fails++; $display("FAIL ghr_cleared: got %h expected 0", bus.ghr_o); end
        foreach (targets[t]) begin
            idle_inputs();
            bus.pred_valid = 1'b1; bus.pred_pc = pc_for(targets[t]);
            tick();
            idle_inputs();
            tick();
        end
        tests++; if (bus.ghr_o !== 4'h6) begin fails++; $display("FAIL ghr_speculate: got %h expected 6", bus.ghr_o); end
        idle_inputs();
        bus.pred_valid = 1'b1; bus.pred_pc = pc_for(3);
        tick();
        tests++; if (bus.pred_rvalid !== 1'b1) begin fails++; $display("FAIL ghr_rvalid_pre: got %b expected 1", bus.pred_rvalid); end
        idle_inputs();
        bus.upd_valid = 1'b1; bus.upd_mispred = 1'b1; bus.upd_idx = 4'd11; bus.upd_ghr = 4'h1; bus.upd_taken = 1'b0;
        tick();
        tests++; if (bus.ghr_o !== 4'h2) begin fails++; $display("FAIL ghr_recover: got %h expected 2", bus.ghr_o); end
        idle_inputs();
        tick();
    endtask

    task automatic test_hash();
        idle_inputs();
        bus.upd_valid = 1'b1; bus.upd_mispred = 1'b1; bus.upd_idx = 4'd12; bus.upd_ghr = 4'h1; bus.upd_taken = 1'b1;
        tick();
        tests++; if (bus.ghr_o !== 4'h3) begin fails++; $display("FAIL hash_ghr_setup: got %h expected 3", bus.ghr_o); end
        idle_inputs();
        bus.pred_valid = 1'b1; bus.pred_pc = 32'h0000_0014;
        tick();
        tests++;
        if (bus.pred_idx !== 4'h6 || bus.pred_ghr !== 4'h3) begin
            fails++;
            $display("FAIL hash_index: idx %h ghr %h expected 6 3", bus.pred_idx, bus.pred_ghr);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            idle_inputs();
            bus.pred_valid  = 1'($urandom_range(0, 3) != 0);
            bus.pred_pc     = $urandom;
            bus.upd_valid   = 1'($urandom_range(0, 1));
            bus.upd_idx     = 4'($urandom_range(0, DEPTH - 1));
            bus.upd_taken   = 1'($urandom_range(0, 1));
            bus.upd_mispred = 1'($urandom_range(0, 3) == 0);
            bus.upd_ghr     = 4'($urandom_range(0, GHR_MOD - 1));
            tick();
            tests++;
            if (bus.pred_rvalid !== m_rvalid || bus.pred_ctr !== 2'(m_ctr) || bus.pred_taken !== m_taken ||
                bus.pred_idx !== 4'(m_idx) || bus.pred_ghr !== 4'(m_snap) || bus.ghr_o !== 4'(m_ghr)) begin
                fails++;
                $display("FAIL random[%0d]: rv %b ctr %0d tk %b idx %0d snap %0d ghr %0d expected %b %0d %b %0d %0d %0d",
                         n, bus.pred_rvalid, bus.pred_ctr, bus.pred_taken, bus.pred_idx, bus.pred_ghr, bus.ghr_o,
                         m_rvalid, m_ctr, m_taken, m_idx, m_snap, m_ghr);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_clr();
        int cnt;
        for (int k = 0; k < 3; k++) begin
            idle_inputs();
            bus.upd_valid = 1'b1; bus.upd_idx = 4'd2; bus.upd_taken = 1'b1;
            tick();
        end
        idle_inputs();
        clr = 1'b1;
        bus.upd_valid = 1'b1; bus.upd_idx = 4'd2; bus.upd_taken = 1'b0;
        bus.pred_valid = 1'b1; bus.pred_pc = pc_for(2);
        tick();
        tests++;
        if (bus.init_busy !== 1'b1 || bus.pred_ready !== 1'b0 || bus.pred_rvalid !== 1'b0 || bus.ghr_o !== 4'h0) begin
            fails++;
            $display("FAIL clr_enter: busy %b ready %b rvalid %b ghr %h expected 1 0 0 0",
                     bus.init_busy, bus.pred_ready, bus.pred_rvalid, bus.ghr_o);
        end
        idle_inputs();
        cnt = 0;
        while (bus.init_busy === 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        tests++; if (cnt != DEPTH) begin fails++; $display("FAIL clr_sweep_cycles: got %0d expected %0d", cnt, DEPTH); end
        bus.pred_valid = 1'b1; bus.pred_pc = pc_for(2);
        tick();
        tests++; if (bus.pred_ctr !== 2'd1 || bus.pred_idx !== 4'd2) begin fails++; $display("FAIL clr_reinit: ctr %0d idx %0d expected 1 2", bus.pred_ctr, bus.pred_idx); end
        idle_inputs();
        tick();
    endtask

    task automatic test_midsweep_reset();
        int cnt;
        idle_inputs();
        clr = 1'b1;
        tick();
        idle_inputs();
        repeat (9) tick();
        #2;
        resetn = 1'b0;
        #1;
        tests++;
        if (bus.init_busy !== 1'b1 || bus.pred_ready !== 1'b0 || bus.pred_ctr !== 2'd0 || bus.pred_idx !== 4'h0 || bus.ghr_o !== 4'h0) begin
            fails++;
            $display("FAIL midsweep_async: busy %b ready %b ctr %0d idx %0d ghr %h expected 1 0 0 0 0",
                     bus.init_busy, bus.pred_ready, bus.pred_ctr, bus.pred_idx, bus.ghr_o);
        end
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cnt = 0;
        while (bus.init_busy === 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        tests++; if (cnt != DEPTH) begin fails++; $display("FAIL midsweep_cycles: got %0d expected %0d", cnt, DEPTH); end
        bus.pred_valid = 1'b1; bus.pred_pc = pc_for(12);
        tick();
        tests++; if (bus.pred_ctr !== 2'd1 || bus.pred_rvalid !== 1'b1) begin fails++; $display("FAIL midsweep_reinit: ctr %0d rvalid %b expected 1 1", bus.pred_ctr, bus.pred_rvalid); end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_init_values();
        test_saturation();
        test_bypass();
        test_ghr();
        test_hash();
        test_random();
        test_clr();
        test_midsweep_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
